// File: rtl/row_weight_load_ctrl_if.sv
// Host/array-side signal bundle for row_weight_load_ctrl.
// fault_mask exists only when ROW_FAULT_SKIP_EN is defined.
interface row_weight_load_ctrl_if #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int WEIGHT_WIDTH  = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
);
    localparam int ROW_W = SYSTOLIC_SIZE * WEIGHT_WIDTH;

    logic                  load_start;
    logic                  feed_start;
    logic                  abort;
    logic                  in_valid;
    logic                  in_ready;
    logic [ROW_W-1:0]      in_data;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ROW_W-1:0]      wr_data;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic                  rd_last;
    logic                  loaded;
    logic                  feed_done;
    logic                  busy;
`ifdef ROW_FAULT_SKIP_EN
    logic [SYSTOLIC_SIZE-1:0] fault_mask;

    modport master (
        output load_start, feed_start, abort, in_valid, in_data, fault_mask,
        input  in_ready, wr_en, wr_addr, wr_data, rd_addr, rd_valid, rd_last,
               loaded, feed_done, busy
    );

    modport slave (
        input  load_start, feed_start, abort, in_valid, in_data, fault_mask,
        output in_ready, wr_en, wr_addr, wr_data, rd_addr, rd_valid, rd_last,
               loaded, feed_done, busy
    );
`else
    modport master (
        output load_start, feed_start, abort, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, rd_addr, rd_valid, rd_last,
               loaded, feed_done, busy
    );

    modport slave (
        input  load_start, feed_start, abort, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, rd_addr, rd_valid, rd_last,
               loaded, feed_done, busy
    );
`endif
endinterface

// File: rtl/row_weight_load_ctrl.sv
// Weight-row buffer sequencer: loads SYSTOLIC_SIZE host rows into the buffer and replays them to the array.
// Defining ROW_FAULT_SKIP_EN adds fault_mask so faulty array rows are skipped during a feed.
module row_weight_load_ctrl #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int WEIGHT_WIDTH  = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    row_weight_load_ctrl_if.slave bus
);
    // state   | meaning
    // IDLE    | no weight set, waiting for load_start
    // LOAD    | accepting host rows, one buffer write per handshake
    // LOADED  | complete set resident, waiting for feed_start or a reload
    // FEED    | replaying buffer rows to the array, one per cycle
    localparam int ROW_W = SYSTOLIC_SIZE * WEIGHT_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] ROWS    = CW'(SYSTOLIC_SIZE);
    localparam logic [CW-1:0] LAST_WR = CW'(SYSTOLIC_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOADED,
        ST_FEED
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
    logic                  loaded_q, loaded_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ROW_W-1:0]      wr_data_q, wr_data_d;
    logic                  feed_done_q, feed_done_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

    logic                     hs;
    logic                     in_ready;
    logic                     rd_valid;
    logic                     rd_last;
    logic [CW-1:0]            rd_next;
    logic [SYSTOLIC_SIZE-1:0] entry_mask;
    logic [SYSTOLIC_SIZE-1:0] skip_mask;

    // Lowest unmasked row at or above start_row; ROWS when none remain.
    function automatic logic [CW-1:0] next_row(input logic [SYSTOLIC_SIZE-1:0] mask,
                                               input logic [CW-1:0]            start_row);
        logic [CW-1:0] r;
        r = ROWS;
        for (int i = SYSTOLIC_SIZE - 1; i >= 0; i--) begin
            if ((CW'(i) >= start_row) && !mask[i]) begin
                r = CW'(i);
            end
        end
        return r;
    endfunction

`ifdef ROW_FAULT_SKIP_EN
    logic [SYSTOLIC_SIZE-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if ((state_q == ST_LOADED) && bus.feed_start && !bus.abort) begin
            mask_d = bus.fault_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign entry_mask = bus.fault_mask;
    assign skip_mask  = mask_q;
`else
    assign entry_mask = '0;
    assign skip_mask  = '0;
`endif

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        loaded_d    = loaded_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        feed_done_d = 1'b0;

        in_ready  = (state_q == ST_LOAD);
        hs        = in_ready && bus.in_valid;
        rd_valid  = (state_q == ST_FEED) && (rd_cnt_q < ROWS);
        rd_next   = next_row(skip_mask, rd_cnt_q + CW'(1));
        rd_last   = rd_valid && (rd_next == ROWS);
        rd_addr_d = rd_valid ? rd_cnt_q[ADDR_WIDTH-1:0] : rd_addr_q;

        // An aborted handshake must not land in the buffer.
        if (hs && !bus.abort) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wr_cnt_q[ADDR_WIDTH-1:0];
            wr_data_d = bus.in_data;
        end

        if (bus.abort) begin
            state_d  = ST_IDLE;
            loaded_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.load_start) begin
                        state_d  = ST_LOAD;
                        wr_cnt_d = '0;
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        wr_cnt_d = wr_cnt_q + CW'(1);
                        if (wr_cnt_q == LAST_WR) begin
                            state_d  = ST_LOADED;
                            loaded_d = 1'b1;
                        end
                    end
                end
                ST_LOADED: begin
                    if (bus.feed_start) begin
                        state_d  = ST_FEED;
                        rd_cnt_d = next_row(entry_mask, '0);
                    end else if (bus.load_start) begin
                        state_d  = ST_LOAD;
                        wr_cnt_d = '0;
                        loaded_d = 1'b0;
                    end
                end
                ST_FEED: begin
                    if (rd_valid && !rd_last) begin
                        rd_cnt_d = rd_next;
                    end else begin
                        state_d     = ST_LOADED;
                        feed_done_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            loaded_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            feed_done_q <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            loaded_q    <= loaded_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            feed_done_q <= feed_done_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_addr   = rd_addr_d;
    assign bus.rd_valid  = rd_valid;
    assign bus.rd_last   = rd_last;
    assign bus.loaded    = loaded_q;
    assign bus.feed_done = feed_done_q;
    assign bus.busy      = (state_q == ST_LOAD) || (state_q == ST_FEED);

endmodule
